dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, REQ-state cycles without bus_ready before abort (used only with DMEM_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 mem_MemRead  input  1  MEM-stage load request.
REQ-005 mem_MemWrite  input  1  MEM-stage store request.
REQ-006 mem_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 mem_alu_result  input  32  effective byte address.
REQ-008 mem_write_data  input  32  store data, lane-0 justified.
REQ-009 bus_req  output  1  data-memory request, held until accepted.
REQ-010 bus_we  output  1  1 = write.
REQ-011 bus_addr  output  32  word-aligned address (bits [1:0] = 00).
REQ-012 bus_wdata  output  32  lane-replicated store data.
REQ-013 bus_wstrb  output  4  byte enables; 0000 on reads.
REQ-014 bus_ready  input  1  completes the request in the same cycle.
REQ-015 bus_rdata  input  32  read word, valid when bus_ready=1.
REQ-016 stall  output  1  freeze IF/ID/EX and the EX/MEM register.
REQ-017 load_data  output  32  sign/zero-extended load result.
REQ-018 load_valid  output  1  one-cycle pulse; load_data valid.
REQ-019 access_fault  output  1  one-cycle pulse: misaligned, illegal funct3, or read+write both set.
REQ-020 bus_error  output  1  one-cycle pulse on timeout abort.

Function
REQ-021 FSM states IDLE, REQ, DONE; stall = (IDLE and legal access present) or REQ; all other outputs registered.
REQ-022 IDLE: legal access -> latch addr/wdata/strb/funct3/we, go REQ; illegal -> pulse access_fault next cycle, no bus_req, no stall, stay IDLE; none -> IDLE.
REQ-023 Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=00; funct3 011/110/111 illegal for loads; funct3 other than 000/001/010 illegal for stores.
REQ-024 REQ: bus_req=1 with stable addr/we/wdata/wstrb; on bus_ready=1 capture extended rdata (loads), go DONE.
REQ-025 DONE: stall=0, bus_req=0, load_valid=1 for loads only; unconditional return to IDLE (pipeline advances, no re-trigger on the same instruction).
REQ-026 Minimum latency: bus_ready in first REQ cycle -> stall high 2 cycles, load_valid in 3rd cycle.
REQ-027 Store lanes: SB wstrb=0001<<addr[1:0], wdata={4{byte}}; SH wstrb=0011<<addr[1:0], wdata={2{half}}; SW 1111.
REQ-028 Load extract: lane chosen by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-029 load_data holds its value until next load completes.

Reset
REQ-030 reset low -> state IDLE immediately; bus_req, bus_we, stall-term, load_valid, access_fault, bus_error = 0; bus_addr, bus_wdata, load_data = 0; bus_wstrb = 0000; timeout counter = 0.
REQ-031 Reset mid-REQ abandons the transaction; bus_req drops asynchronously; no load_valid after release.

Configuration
REQ-032 Macro DMEM_TIMEOUT_EN defined: counter increments each REQ cycle without bus_ready; at TIMEOUT_CYCLES pulse bus_error, load_data=0, go DONE (no load_valid); counter clears on leaving REQ.
REQ-033 DMEM_TIMEOUT_EN undefined: REQ waits indefinitely; bus_error tied 0; no counter logic.

Verification
REQ-034 LW addr 0x100, bus_ready on first REQ cycle, rdata 0xDEADBEEF -> stall 2 cycles, load_valid cycle 3, load_data 0xDEADBEEF, bus_addr 0x100.
REQ-035 LB addr 0x203, rdata 0x80FF1234 -> load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SH addr 0x302, data 0x0000ABCD -> bus_we=1, bus_addr 0x300, wstrb 1100, wdata 0xABCDABCD, no load_valid.
REQ-037 LW addr 0x101 -> access_fault pulse, bus_req never 1, stall never 1.
REQ-038 bus_ready held 0, DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4 -> bus_error after 4 REQ cycles, load_data 0, stall drops in DONE.
REQ-039 reset asserted during 3rd REQ wait cycle -> bus_req and stall 0 immediately; after release, IDLE, no load_valid.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the access controller (master) and memory (slave).
//   bus_req   : request, held until bus_ready
//   bus_we    : 1 = write
//   bus_addr  : word-aligned address
//   bus_wdata : lane-replicated store data
//   bus_wstrb : byte enables, 0000 on reads
//   bus_ready : completes the request in the same cycle
//   bus_rdata : read word, valid with bus_ready
interface dmem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Turns a load/store from the EX/MEM register into a single bus transaction,
// stalling the front of the pipeline until the bus completes.
//   clk, reset        : clock, asynchronous active-low reset
//   mem_MemRead/Write : load/store request from EX/MEM
//   mem_funct3        : size/sign (B,H,W,BU,HU)
//   mem_alu_result    : effective byte address
//   mem_write_data    : store data, lane-0 justified
//   bus               : data-memory bus (master side)
//   stall             : freeze IF/ID/EX and EX/MEM
//   load_data         : extended load result, held until next load
//   load_valid        : one-cycle pulse with load_data
//   access_fault      : one-cycle pulse on misaligned/illegal access
//   bus_error         : one-cycle pulse on timeout abort
// Optional feature: define DMEM_TIMEOUT_EN to abort a request after
// TIMEOUT_CYCLES cycles without bus_ready.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  dmem_access_ctrl_if.master bus,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_fault,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        fault_q, fault_d;

  logic        has_acc, f3_bad, misal, illegal, legal;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c, rsh, ext_c;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             berr_q, berr_d;
`endif

  // Access decode
  always_comb begin
    has_acc = mem_MemRead | mem_MemWrite;
    if (mem_MemWrite) f3_bad = mem_funct3[2] | (mem_funct3[1:0] == 2'b11);
    else              f3_bad = (mem_funct3[1:0] == 2'b11) | (mem_funct3 == 3'b110);
    misal = ((mem_funct3[1:0] == 2'b01) & mem_alu_result[0]) |
            ((mem_funct3[1:0] == 2'b10) & (mem_alu_result[1:0] != 2'b00));
    illegal = has_acc & ((mem_MemRead & mem_MemWrite) | f3_bad | misal);
    legal   = has_acc & ~illegal;

    case (mem_funct3[1:0])
      2'b00:   begin strb_c = 4'b0001 << mem_alu_result[1:0]; wdata_c = {4{mem_write_data[7:0]}};  end
      2'b01:   begin strb_c = 4'b0011 << mem_alu_result[1:0]; wdata_c = {2{mem_write_data[15:0]}}; end
      default: begin strb_c = 4'b1111;                        wdata_c = mem_write_data;            end
    endcase

    // Bring the addressed lane down to bit 0, then extend
    rsh = bus.bus_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ext_c = {{24{rsh[7]}}, rsh[7:0]};
      3'b001:  ext_c = {{16{rsh[15]}}, rsh[15:0]};
      3'b100:  ext_c = {24'h0, rsh[7:0]};
      3'b101:  ext_c = {16'h0, rsh[15:0]};
      default: ext_c = bus.bus_rdata;
    endcase
  end

  // Next state
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    fault_d      = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d        = '0;
    berr_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (legal) begin
          state_d   = REQ;
          bus_req_d = 1'b1;
          we_d      = mem_MemWrite;
          addr_d    = {mem_alu_result[31:2], 2'b00};
          wdata_d   = wdata_c;
          wstrb_d   = mem_MemWrite ? strb_c : 4'b0000;
          funct3_d  = mem_funct3;
          off_d     = mem_alu_result[1:0];
        end else if (illegal) begin
          fault_d = 1'b1;
        end
      end
      REQ: begin
        if (bus.bus_ready) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          if (!we_q) begin
            load_data_d  = ext_c;
            load_valid_d = 1'b1;
          end
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          berr_d      = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      // Pipeline advances this cycle; never re-trigger on the same instruction
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q        <= '0;
      berr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
      berr_q       <= berr_d;
`endif
    end
  end

  // Gated by reset so a request still presented during reset does not stall
  assign stall = reset & (((state_q == IDLE) & legal) | (state_q == REQ));

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_wstrb = wstrb_q;
  assign load_data     = load_data_q;
  assign load_valid    = load_valid_q;
  assign access_fault  = fault_q;
`ifdef DMEM_TIMEOUT_EN
  assign bus_error     = berr_q;
`else
  assign bus_error     = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: loads/stores with hand-computed
// lanes and extensions, fault cases, reset mid-request, timeout abort.
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [2:0]  f3;
  logic [31:0] addr, wd;
  logic        stall, load_valid, access_fault, bus_error;
  logic [31:0] load_data;
  logic [31:0] hold_ld;
  int          n_vec = 0;
  int          n_err = 0;

  dmem_access_ctrl_if bus_if();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .mem_MemRead(rd), .mem_MemWrite(wr), .mem_funct3(f3),
    .mem_alu_result(addr), .mem_write_data(wd),
    .bus(bus_if),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .access_fault(access_fault), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    rd = 0; wr = 0; f3 = 3'b000; addr = '0; wd = '0;
    bus_if.bus_ready = 0; bus_if.bus_rdata = '0;
  endtask

  // Legal access: IDLE stall cycle, `waits` REQ cycles without ready, then ready
  task automatic run_acc(input string tg, input logic r, input logic w, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] d, input int waits,
                         input logic [31:0] rdv, input logic [31:0] e_addr,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata,
                         input logic [31:0] e_ld);
    rd = r; wr = w; f3 = fn; addr = a; wd = d;
    #1;
    chk({tg, ".stall_idle"}, {31'b0, stall}, 1);
    chk({tg, ".req_idle"}, {31'b0, bus_if.bus_req}, 0);
    tick();
    for (int i = 0; i <= waits; i++) begin
      bus_if.bus_ready = (i == waits);
      bus_if.bus_rdata = rdv;
      chk({tg, ".req"}, {31'b0, bus_if.bus_req}, 1);
      chk({tg, ".stall_req"}, {31'b0, stall}, 1);
      chk({tg, ".berr_wait"}, {31'b0, bus_error}, 0);
      if (i == 0) begin
        chk({tg, ".addr"}, bus_if.bus_addr, e_addr);
        chk({tg, ".we"}, {31'b0, bus_if.bus_we}, {31'b0, w});
        chk({tg, ".strb"}, {28'b0, bus_if.bus_wstrb}, {28'b0, e_strb});
        if (w) chk({tg, ".wdata"}, bus_if.bus_wdata, e_wdata);
      end
      tick();
    end
    idle_in();
    #1;
    chk({tg, ".stall_done"}, {31'b0, stall}, 0);
    chk({tg, ".req_done"}, {31'b0, bus_if.bus_req}, 0);
    chk({tg, ".lvalid"}, {31'b0, load_valid}, {31'b0, r});
    if (r) hold_ld = e_ld;
    chk({tg, ".ldata"}, load_data, hold_ld);
    tick();
    chk({tg, ".lvalid_off"}, {31'b0, load_valid}, 0);
    chk({tg, ".ldata_hold"}, load_data, hold_ld);
  endtask

  task automatic run_fault(input string tg, input logic r, input logic w,
                           input logic [2:0] fn, input logic [31:0] a);
    rd = r; wr = w; f3 = fn; addr = a; wd = 32'h1234_5678;
    #1;
    chk({tg, ".stall"}, {31'b0, stall}, 0);
    tick();
    idle_in();
    #1;
    chk({tg, ".fault"}, {31'b0, access_fault}, 1);
    chk({tg, ".req"}, {31'b0, bus_if.bus_req}, 0);
    chk({tg, ".stall2"}, {31'b0, stall}, 0);
    tick();
    chk({tg, ".fault_off"}, {31'b0, access_fault}, 0);
    chk({tg, ".req2"}, {31'b0, bus_if.bus_req}, 0);
  endtask

  initial begin
    idle_in();
    hold_ld = '0;
    reset = 0;
    #23;
    chk("rst.req",   {31'b0, bus_if.bus_req}, 0);
    chk("rst.we",    {31'b0, bus_if.bus_we}, 0);
    chk("rst.addr",  bus_if.bus_addr, 0);
    chk("rst.wdata", bus_if.bus_wdata, 0);
    chk("rst.strb",  {28'b0, bus_if.bus_wstrb}, 0);
    chk("rst.stall", {31'b0, stall}, 0);
    chk("rst.ldata", load_data, 0);
    chk("rst.lval",  {31'b0, load_valid}, 0);
    chk("rst.fault", {31'b0, access_fault}, 0);
    chk("rst.berr",  {31'b0, bus_error}, 0);
    reset = 1;
    tick();

    //        tag    rd wr f3      addr          wdata         wt rdata         e_addr        strb     e_wdata       e_ld
    run_acc("lw",   1, 0, 3'b010, 32'h100, 32'h0,         0, 32'hDEADBEEF, 32'h100, 4'b0000, 32'h0,         32'hDEADBEEF);
    run_acc("lb",   1, 0, 3'b000, 32'h203, 32'h0,         0, 32'h80FF1234, 32'h200, 4'b0000, 32'h0,         32'hFFFFFF80);
    run_acc("lbu",  1, 0, 3'b100, 32'h203, 32'h0,         1, 32'h80FF1234, 32'h200, 4'b0000, 32'h0,         32'h00000080);
    run_acc("lh",   1, 0, 3'b001, 32'h202, 32'h0,         0, 32'h80FF1234, 32'h200, 4'b0000, 32'h0,         32'hFFFF80FF);
    run_acc("lhu",  1, 0, 3'b101, 32'h202, 32'h0,         0, 32'h80FF1234, 32'h200, 4'b0000, 32'h0,         32'h000080FF);
    run_acc("lh0",  1, 0, 3'b001, 32'h200, 32'h0,         0, 32'h80FF1234, 32'h200, 4'b0000, 32'h0,         32'h00001234);
    run_acc("lb1",  1, 0, 3'b000, 32'h201, 32'h0,         0, 32'h80FF1234, 32'h200, 4'b0000, 32'h0,         32'h00000012);
    run_acc("sh",   0, 1, 3'b001, 32'h302, 32'h0000ABCD,  2, 32'h0,        32'h300, 4'b1100, 32'hABCDABCD,  32'h0);
    run_acc("sb",   0, 1, 3'b000, 32'h401, 32'h1234565A,  0, 32'h0,        32'h400, 4'b0010, 32'h5A5A5A5A,  32'h0);
    run_acc("sw",   0, 1, 3'b010, 32'h500, 32'hCAFEF00D,  0, 32'h0,        32'h500, 4'b1111, 32'hCAFEF00D,  32'h0);
`ifndef DMEM_TIMEOUT_EN
    run_acc("lwait",1, 0, 3'b010, 32'h700, 32'h0,         6, 32'h01020304, 32'h700, 4'b0000, 32'h0,         32'h01020304);
`endif

    run_fault("f_lw101", 1, 0, 3'b010, 32'h101);
    run_fault("f_sh303", 0, 1, 3'b001, 32'h303);
    run_fault("f_ld011", 1, 0, 3'b011, 32'h000);
    run_fault("f_st100", 0, 1, 3'b100, 32'h000);
    run_fault("f_rdwr",  1, 1, 3'b010, 32'h000);

    // Reset during the third REQ wait cycle
    rd = 1; f3 = 3'b010; addr = 32'h800;
    tick();
    tick(); tick();
    chk("rstmid.req_before", {31'b0, bus_if.bus_req}, 1);
    reset = 0;
    #1;
    chk("rstmid.req",   {31'b0, bus_if.bus_req}, 0);
    chk("rstmid.stall", {31'b0, stall}, 0);
    idle_in();
    #2;
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid.lval", {31'b0, load_valid}, 0);
      chk("rstmid.req2", {31'b0, bus_if.bus_req}, 0);
    end
    hold_ld = '0;
    run_acc("post_rst", 1, 0, 3'b010, 32'h900, 32'h0, 0, 32'h55AA55AA, 32'h900, 4'b0000, 32'h0, 32'h55AA55AA);

`ifdef DMEM_TIMEOUT_EN
    // Bus never ready: abort after 4 REQ cycles
    rd = 1; f3 = 3'b010; addr = 32'h600;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to.req", {31'b0, bus_if.bus_req}, 1);
      chk("to.berr_wait", {31'b0, bus_error}, 0);
      tick();
    end
    idle_in();
    #1;
    chk("to.berr",  {31'b0, bus_error}, 1);
    chk("to.ldata", load_data, 0);
    chk("to.lval",  {31'b0, load_valid}, 0);
    chk("to.stall", {31'b0, stall}, 0);
    chk("to.req_off", {31'b0, bus_if.bus_req}, 0);
    tick();
    chk("to.berr_off", {31'b0, bus_error}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
